// File: rtl/game_pkg.sv
// Shared types and constants for the Saper board-geometry generator:
// difficulty levels, the per-level table and default screen geometry.
package game_pkg;

  typedef enum logic [1:0] {
    LVL_EASY   = 2'd0,
    LVL_MEDIUM = 2'd1,
    LVL_HARD   = 2'd2,
    LVL_CUSTOM = 2'd3
  } level_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_DIVIDE,
    ST_COMPUTE,
    ST_COMMIT
  } state_t;

  localparam int EASY_N       = 8;
  localparam int EASY_MINES   = 10;
  localparam int MEDIUM_N     = 16;
  localparam int MEDIUM_MINES = 40;
  localparam int HARD_N       = 24;
  localparam int HARD_MINES   = 99;

  localparam int DEF_SCREEN_W     = 1024;
  localparam int DEF_SCREEN_H     = 768;
  localparam int DEF_TARGET_BOARD = 600;

endpackage

// File: rtl/game_settings_gen_if.sv
// Configuration request/response bundle between the game controller
// (master) and the settings generator (slave).
interface game_settings_gen_if
  import game_pkg::*;
#(
  parameter int BTN_NUM_W  = 5,
  parameter int SIZE_W     = 10,
  parameter int POS_W      = 11,
  parameter int BTN_SIZE_W = 7,
  parameter int MINES_W    = 10
) ();

  logic                  cfg_req;
  level_t                cfg_level;
  logic [BTN_NUM_W-1:0]  cust_button_num;
  logic [MINES_W-1:0]    cust_mines;

  logic                  cfg_busy;
  logic                  cfg_done;
  logic                  cfg_err;
  logic [BTN_NUM_W-1:0]  button_num;
  logic [BTN_SIZE_W-1:0] button_size;
  logic [SIZE_W-1:0]     board_size;
  logic [POS_W-1:0]      board_xpos;
  logic [POS_W-1:0]      board_ypos;
  logic [MINES_W-1:0]    mines;

  modport master (
    output cfg_req, cfg_level, cust_button_num, cust_mines,
    input  cfg_busy, cfg_done, cfg_err, button_num, button_size,
           board_size, board_xpos, board_ypos, mines
  );

  modport slave (
    input  cfg_req, cfg_level, cust_button_num, cust_mines,
    output cfg_busy, cfg_done, cfg_err, button_num, button_size,
           board_size, board_xpos, board_ypos, mines
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. done is high during
// the final iteration; quotient/remainder are valid from the next cycle on.
module seq_divider #(
  parameter int SIZE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] dividend,
  input  logic [SIZE_W-1:0] divisor,
  output logic              done,
  output logic [SIZE_W-1:0] quotient,
  output logic [SIZE_W-1:0] remainder
);

  localparam int CNT_W = $clog2(SIZE_W + 1);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [SIZE_W-1:0] quo;
  logic [SIZE_W-1:0] rem;
  logic [SIZE_W-1:0] dvs;
  logic [SIZE_W:0]   shifted;
  logic [SIZE_W:0]   diff;

  // Bring down the next dividend bit and try subtracting the divisor.
  assign shifted = {rem, quo[SIZE_W-1]};
  assign diff    = shifted - {1'b0, dvs};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain iterations within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(SIZE_W);
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (busy) begin
      if (!diff[SIZE_W]) begin
        rem <= diff[SIZE_W-1:0];
        quo <= {quo[SIZE_W-2:0], 1'b1};
      end else begin
        rem <= shifted[SIZE_W-1:0];
        quo <= {quo[SIZE_W-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  assign done      = busy && (cnt == CNT_W'(1));
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/game_settings_gen.sv
// Board-geometry generator: level lookup, serial divide for button size,
// then board size and centred position, committed as one atomic set.
module game_settings_gen
  import game_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int TARGET_BOARD = DEF_TARGET_BOARD,
  parameter int BTN_NUM_W    = 5,
  parameter int SIZE_W       = 10,
  parameter int POS_W        = 11,
  parameter int BTN_SIZE_W   = 7,
  parameter int MINES_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  game_settings_gen_if.slave cfg
);

  localparam int CMP_W  = (2 * BTN_NUM_W > MINES_W) ? 2 * BTN_NUM_W : MINES_W;
  localparam int BS_MAX = (1 << BTN_SIZE_W) - 1;

  state_t                state;
  level_t                level_r;
  logic [BTN_NUM_W-1:0]  cust_n_r;
  logic [MINES_W-1:0]    cust_m_r;
  logic [BTN_NUM_W-1:0]  n_r;
  logic [MINES_W-1:0]    m_r;
  logic [BTN_SIZE_W-1:0] bs_r;
  logic [SIZE_W-1:0]     bsize_r;
  logic [POS_W-1:0]      x_r;
  logic [POS_W-1:0]      y_r;

  logic                  done_q;
  logic                  err_q;
  logic [BTN_NUM_W-1:0]  button_num_q;
  logic [BTN_SIZE_W-1:0] button_size_q;
  logic [SIZE_W-1:0]     board_size_q;
  logic [POS_W-1:0]      board_xpos_q;
  logic [POS_W-1:0]      board_ypos_q;
  logic [MINES_W-1:0]    mines_q;

  logic [BTN_NUM_W-1:0]  lk_n;
  logic [MINES_W-1:0]    lk_m;
  logic [CMP_W-1:0]      n_ext;
  logic [CMP_W-1:0]      nn;
  logic [CMP_W-1:0]      m_ext;
  logic                  lk_invalid;

  logic                  div_start;
  logic                  div_done;
  logic [SIZE_W-1:0]     div_q;
  logic [SIZE_W-1:0]     div_rem_unused;

  logic [BTN_SIZE_W-1:0] bs_c;
  logic [SIZE_W-1:0]     bsize_c;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    lk_n = cust_n_r;
    lk_m = cust_m_r;
    case (level_r)
      LVL_EASY:   begin lk_n = BTN_NUM_W'(EASY_N);   lk_m = MINES_W'(EASY_MINES);   end
      LVL_MEDIUM: begin lk_n = BTN_NUM_W'(MEDIUM_N); lk_m = MINES_W'(MEDIUM_MINES); end
      LVL_HARD:   begin lk_n = BTN_NUM_W'(HARD_N);   lk_m = MINES_W'(HARD_MINES);   end
      default:    ;
    endcase
    n_ext      = CMP_W'(lk_n);
    nn         = n_ext * n_ext;
    m_ext      = CMP_W'(lk_m);
    lk_invalid = (lk_n < BTN_NUM_W'(2)) || (lk_m == '0) || (m_ext >= nn);
  end

  assign div_start = (state == ST_LOOKUP) && !lk_invalid;

  seq_divider #(.SIZE_W(SIZE_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (SIZE_W'(TARGET_BOARD)),
    .divisor   (SIZE_W'(lk_n)),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem_unused)
  );

  // Clamping the button edge keeps bs*n within the target board.
  assign bs_c    = (div_q > SIZE_W'(BS_MAX)) ? BTN_SIZE_W'(BS_MAX) : BTN_SIZE_W'(div_q);
  assign bsize_c = SIZE_W'(bs_c) * SIZE_W'(n_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      level_r       <= LVL_EASY;
      cust_n_r      <= '0;
      cust_m_r      <= '0;
      n_r           <= '0;
      m_r           <= '0;
      bs_r          <= '0;
      bsize_r       <= '0;
      x_r           <= '0;
      y_r           <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      button_num_q  <= '0;
      button_size_q <= '0;
      board_size_q  <= '0;
      board_xpos_q  <= '0;
      board_ypos_q  <= '0;
      mines_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_req) begin
            level_r  <= cfg.cfg_level;
            cust_n_r <= cfg.cust_button_num;
            cust_m_r <= cfg.cust_mines;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lk_invalid) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            n_r   <= lk_n;
            m_r   <= lk_m;
            state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (div_done) state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          bs_r    <= bs_c;
          bsize_r <= bsize_c;
          x_r     <= POS_W'((32'(SCREEN_W) - 32'(bsize_c)) >> 1);
          y_r     <= POS_W'((32'(SCREEN_H) - 32'(bsize_c)) >> 1);
          state   <= ST_COMMIT;
        end
        ST_COMMIT: begin
          button_num_q  <= n_r;
          button_size_q <= bs_r;
          board_size_q  <= bsize_r;
          board_xpos_q  <= x_r;
          board_ypos_q  <= y_r;
          mines_q       <= m_r;
          done_q        <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cfg.cfg_busy    = (state != ST_IDLE);
  assign cfg.cfg_done    = done_q;
  assign cfg.cfg_err     = err_q;
  assign cfg.button_num  = button_num_q;
  assign cfg.button_size = button_size_q;
  assign cfg.board_size  = board_size_q;
  assign cfg.board_xpos  = board_xpos_q;
  assign cfg.board_ypos  = board_ypos_q;
  assign cfg.mines       = mines_q;

endmodule
